fp_stim_gen: RTL and testbench
==============================

FP_STIM_GEN -- requirements
Module: fp_stim_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter EXP_BITS, default 8, exponent field width.
REQ-003 SHALL have parameter MANT_BITS, default 23, mantissa field width; WIDTH = 1+EXP_BITS+MANT_BITS (elaboration error otherwise).
REQ-004 SHALL have parameter SEED, default 32'h1, LFSR reset/fallback seed (nonzero).
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin burst (sampled in IDLE only).
- abort  in  1  terminate burst.
- mode_a  in  4  operand A stimulus class.
- mode_b  in  4  operand B stimulus class.
- op_mode  in  2  0 add, 1 sub, 2 random, 3 alternate.
- order  in  2  0 none, 1 force a>b, 2 force a<b (unsigned compare).
- burst_len  in  16  pairs per burst, 0 = unbounded.
- seed_load  in  1  load seed (IDLE only).
- seed  in  32  LFSR seed.
- out_valid  out  1  pair valid.
- out_ready  in  1  consumer accepts.
- a, b  out  WIDTH  operands.
- operation_select  out  1  0 add, 1 sub.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle end-of-burst pulse.

Function
REQ-006 Modes SHALL be: 0 ZERO; 1 QNAN (exp all-ones, mant MSB 1, rest 0); 2 POS_INF; 3 NEG_INF; 4 MAX_POS (exp all-ones-minus-1, mant all-ones); 5 MAX_NEG; 6 MIN_NORM_POS (exp 1, mant 0); 7 MIN_NORM_NEG; 8 MIN_DENORM_POS (exp 0, mant 1); 9 MIN_DENORM_NEG; 10 RANDOM (full LFSR word); 11 NEAR_ONE (sign 0, exp {1,0..0,r[1:0]}, mant {r[2:0],0..0}); 12 FIXED_ONE (exp = bias, mant 0); 13-15 treated as ZERO.
REQ-007 A and B SHALL draw independent random words: each accepted pair advances the LFSR twice (first word A, second B).
REQ-008 LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1; operands wider than 32 concatenate successive states, narrower truncate LSBs.
REQ-009 order=1/2 SHALL swap a,b when the relation fails; a==b SHALL be output unchanged.
REQ-010 op_mode 2 SHALL take operation_select from LFSR bit 0 of the B word; op_mode 3 SHALL start at 0 and toggle per accepted pair.
REQ-011 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance of final pair; RUN->IDLE on abort; DONE->IDLE unconditionally after one cycle.
REQ-012 First pair SHALL be valid in the cycle after start; throughput one pair per cycle while out_ready=1.
REQ-013 a, b, operation_select SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 abort SHALL deassert out_valid next cycle even mid-stall, no done pulse; abort has priority over final acceptance.
REQ-015 mode/order/op_mode SHALL be sampled at start and held for the burst.
REQ-016 start while busy SHALL be ignored; seed_load outside IDLE ignored; seed 0 SHALL load SEED.
REQ-017 burst_len=0 SHALL run until abort; pair counter SHALL not wrap.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, out_valid/busy/done/operation_select 0, a/b 0, LFSR=SEED, counter 0.
REQ-019 Reset mid-burst SHALL discard the burst; no done pulse on release.

Structure
REQ-020 Package fp_stim_pkg SHALL hold mode, op_mode, order and state enums, polynomial constant, and special-value constructor functions parametrised by EXP_BITS/MANT_BITS.
REQ-021 LFSR SHALL be sub-module fp_stim_lfsr (load, advance, state out).

Verification
REQ-022 mode_a=2, mode_b=1, op_mode=1, burst_len=3, ready=1 -> three pairs a=7f800000 b=7fc00000 op=1, done on cycle 4.
REQ-023 mode_a=mode_b=10, order=1, burst_len=100 -> every pair a>=b unsigned; reseeding with same seed reproduces identical sequence.
REQ-024 burst_len=4, out_ready toggling -> exactly 4 handshakes, operands stable across stalls.
REQ-025 op_mode=3, burst_len=5 -> operation_select 0,1,0,1,0.
REQ-026 burst_len=0, abort at pair 7 while stalled -> out_valid low next cycle, busy low, no done.
REQ-027 rst_n low mid-burst, then start with SEED default -> first random pair equals post-reset first pair.

Source files
------------

// File: rtl/fp_stim_pkg.sv
// rtl/fp_stim_pkg.sv - shared types, LFSR polynomial and FP special-value constructors
package fp_stim_pkg;

   localparam int FP_MAX_W = 128;
   // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   typedef enum logic [3:0] {
      MODE_ZERO           = 4'd0,
      MODE_QNAN           = 4'd1,
      MODE_POS_INF        = 4'd2,
      MODE_NEG_INF        = 4'd3,
      MODE_MAX_POS        = 4'd4,
      MODE_MAX_NEG        = 4'd5,
      MODE_MIN_NORM_POS   = 4'd6,
      MODE_MIN_NORM_NEG   = 4'd7,
      MODE_MIN_DENORM_POS = 4'd8,
      MODE_MIN_DENORM_NEG = 4'd9,
      MODE_RANDOM         = 4'd10,
      MODE_NEAR_ONE       = 4'd11,
      MODE_FIXED_ONE      = 4'd12
   } fp_mode_e;

   typedef enum logic [1:0] {
      OP_ADD    = 2'd0,
      OP_SUB    = 2'd1,
      OP_RANDOM = 2'd2,
      OP_ALT    = 2'd3
   } op_mode_e;

   typedef enum logic [1:0] {
      ORD_NONE   = 2'd0,
      ORD_A_GT_B = 2'd1,
      ORD_A_LT_B = 2'd2
   } order_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   function automatic logic [FP_MAX_W-1:0] fp_mask(input int n);
      fp_mask = (FP_MAX_W'(1) << n) - FP_MAX_W'(1);
   endfunction

   function automatic logic [FP_MAX_W-1:0] fp_pack(input logic s,
                                                   input logic [FP_MAX_W-1:0] e,
                                                   input logic [FP_MAX_W-1:0] m,
                                                   input int eb, input int mb);
      fp_pack = ({{(FP_MAX_W-1){1'b0}}, s} << (eb + mb))
              | ((e & fp_mask(eb)) << mb)
              | (m & fp_mask(mb));
   endfunction

   function automatic logic [FP_MAX_W-1:0] fp_special(input logic [3:0] mode,
                                                      input logic [FP_MAX_W-1:0] rnd,
                                                      input int eb, input int mb);
      logic [FP_MAX_W-1:0] one;
      logic [FP_MAX_W-1:0] ones_e;
      one    = FP_MAX_W'(1);
      ones_e = fp_mask(eb);
      fp_special = '0;
      case (mode)
         MODE_QNAN:           fp_special = fp_pack(1'b0, ones_e, one << (mb - 1), eb, mb);
         MODE_POS_INF:        fp_special = fp_pack(1'b0, ones_e, '0, eb, mb);
         MODE_NEG_INF:        fp_special = fp_pack(1'b1, ones_e, '0, eb, mb);
         MODE_MAX_POS:        fp_special = fp_pack(1'b0, ones_e - one, fp_mask(mb), eb, mb);
         MODE_MAX_NEG:        fp_special = fp_pack(1'b1, ones_e - one, fp_mask(mb), eb, mb);
         MODE_MIN_NORM_POS:   fp_special = fp_pack(1'b0, one, '0, eb, mb);
         MODE_MIN_NORM_NEG:   fp_special = fp_pack(1'b1, one, '0, eb, mb);
         MODE_MIN_DENORM_POS: fp_special = fp_pack(1'b0, '0, one, eb, mb);
         MODE_MIN_DENORM_NEG: fp_special = fp_pack(1'b1, '0, one, eb, mb);
         MODE_RANDOM:         fp_special = rnd;
         MODE_NEAR_ONE:       fp_special = fp_pack(1'b0, (one << (eb - 1)) | (rnd & FP_MAX_W'(3)),
                                                   (rnd & FP_MAX_W'(7)) << (mb - 3), eb, mb);
         MODE_FIXED_ONE:      fp_special = fp_pack(1'b0, fp_mask(eb - 1), '0, eb, mb);
         default:             fp_special = '0;
      endcase
   endfunction

endpackage

// File: rtl/fp_stim_lfsr.sv
// rtl/fp_stim_lfsr.sv - Galois LFSR exposing the next NSTATES successive states
module fp_stim_lfsr
   import fp_stim_pkg::*;
#(
   parameter logic [31:0] SEED    = 32'h1,
   parameter int          NSTATES = 2
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_load,
   input  logic [31:0]               i_seed,
   input  logic                      i_advance,
   output logic [NSTATES-1:0][31:0]  o_chain
);

   logic [31:0] r_state;
   logic [31:0] w_seed_eff;
   logic [31:0] w_src;
   logic [31:0] w_walk;

   // A zero seed would lock the register, so it falls back to SEED
   assign w_seed_eff = (i_seed == 32'h0) ? SEED : i_seed;
   assign w_src      = i_load ? w_seed_eff : r_state;

   always_comb begin
      w_walk  = w_src;
      o_chain = '0;
      for (int i = 0; i < NSTATES; i++) begin
         o_chain[i] = w_walk;
         w_walk     = lfsr_step(w_walk);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= SEED;
      else if (i_advance)
         r_state <= w_walk;
      else if (i_load)
         r_state <= w_seed_eff;
   end

endmodule

// File: rtl/fp_stim_gen.sv
// rtl/fp_stim_gen.sv - floating-point operand pair stimulus generator
module fp_stim_gen
   import fp_stim_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter int          EXP_BITS  = 8,
   parameter int          MANT_BITS = 23,
   parameter logic [31:0] SEED      = 32'h1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [3:0]       mode_a,
   input  logic [3:0]       mode_b,
   input  logic [1:0]       op_mode,
   input  logic [1:0]       order,
   input  logic [15:0]      burst_len,
   input  logic             seed_load,
   input  logic [31:0]      seed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             operation_select,
   output logic             busy,
   output logic             done
);

   localparam int NW = (WIDTH + 31) / 32;

   generate
      if (WIDTH != 1 + EXP_BITS + MANT_BITS || WIDTH > FP_MAX_W || EXP_BITS < 2 || MANT_BITS < 3) begin : g_bad_cfg
         $error("fp_stim_gen: WIDTH must equal 1+EXP_BITS+MANT_BITS and fit FP_MAX_W");
      end
   endgenerate

   state_e              r_state, w_state_nxt;
   logic [3:0]          r_mode_a, r_mode_b;
   logic [1:0]          r_op_mode, r_order;
   logic [15:0]         r_len, r_cnt;
   logic                r_valid, r_opsel;
   logic [WIDTH-1:0]    r_a, r_b;

   logic                w_idle, w_accept, w_last, w_gen, w_load, w_swap, w_opsel_nxt;
   logic [3:0]          w_ma, w_mb;
   logic [1:0]          w_opm, w_ord;
   logic [2*NW-1:0][31:0] w_chain;
   logic [FP_MAX_W-1:0] w_rnd_a, w_rnd_b;
   logic [WIDTH-1:0]    w_a_raw, w_b_raw, w_a_nxt, w_b_nxt;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_load   = w_idle & seed_load;
   assign w_accept = r_valid & out_ready;
   assign w_last   = (r_len != 16'd0) && (r_cnt == r_len - 16'd1);

   // Configuration comes straight from the ports on the start cycle, then from the held copy
   assign w_ma  = w_idle ? mode_a  : r_mode_a;
   assign w_mb  = w_idle ? mode_b  : r_mode_b;
   assign w_opm = w_idle ? op_mode : r_op_mode;
   assign w_ord = w_idle ? order   : r_order;

   fp_stim_lfsr #(
      .SEED    (SEED),
      .NSTATES (2 * NW)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load),
      .i_seed    (seed),
      .i_advance (w_gen),
      .o_chain   (w_chain)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_gen       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_gen       = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort)
               w_state_nxt = ST_IDLE;
            else if (w_accept && w_last)
               w_state_nxt = ST_DONE;
            else if (w_accept)
               w_gen = 1'b1;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rnd_a = '0;
      w_rnd_b = '0;
      for (int i = 0; i < NW; i++) begin
         w_rnd_a[i*32 +: 32] = w_chain[i];
         w_rnd_b[i*32 +: 32] = w_chain[NW+i];
      end
   end

   always_comb begin
      w_a_raw = WIDTH'(fp_special(w_ma, w_rnd_a, EXP_BITS, MANT_BITS));
      w_b_raw = WIDTH'(fp_special(w_mb, w_rnd_b, EXP_BITS, MANT_BITS));
      w_swap  = 1'b0;
      case (w_ord)
         ORD_A_GT_B: w_swap = (w_a_raw < w_b_raw);
         ORD_A_LT_B: w_swap = (w_a_raw > w_b_raw);
         default:    w_swap = 1'b0;
      endcase
      w_a_nxt = w_swap ? w_b_raw : w_a_raw;
      w_b_nxt = w_swap ? w_a_raw : w_b_raw;
      case (w_opm)
         OP_ADD:    w_opsel_nxt = 1'b0;
         OP_SUB:    w_opsel_nxt = 1'b1;
         OP_RANDOM: w_opsel_nxt = w_rnd_b[0];
         default:   w_opsel_nxt = w_idle ? 1'b0 : ~r_opsel;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_a  <= '0;
         r_mode_b  <= '0;
         r_op_mode <= '0;
         r_order   <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_opsel   <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
      end else begin
         r_valid <= (w_state_nxt == ST_RUN);
         if (w_idle && start) begin
            r_mode_a  <= mode_a;
            r_mode_b  <= mode_b;
            r_op_mode <= op_mode;
            r_order   <= order;
            r_len     <= burst_len;
            r_cnt     <= '0;
         end else if (r_state == ST_RUN && w_accept && !abort && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_gen) begin
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_opsel <= w_opsel_nxt;
         end
      end
   end

   assign out_valid        = r_valid;
   assign a                = r_a;
   assign b                = r_b;
   assign operation_select = r_opsel;
   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_DONE);

endmodule

// File: tb/tb_fp_stim_gen.sv
// tb/tb_fp_stim_gen.sv - self-checking bench for fp_stim_gen
module tb_fp_stim_gen;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, seed_load, out_ready;
   logic [3:0]  mode_a, mode_b;
   logic [1:0]  op_mode, order;
   logic [15:0] burst_len;
   logic [31:0] seed;
   logic        out_valid, operation_select, busy, done;
   logic [31:0] a, b;

   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;
   logic [31:0] m_lfsr;

   always #5 clk = ~clk;

   fp_stim_gen dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .mode_a           (mode_a),
      .mode_b           (mode_b),
      .op_mode          (op_mode),
      .order            (order),
      .burst_len        (burst_len),
      .seed_load        (seed_load),
      .seed             (seed),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .a                (a),
      .b                (b),
      .operation_select (operation_select),
      .busy             (busy),
      .done             (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Polynomial x^32+x^22+x^2+x+1 as right-shift Galois taps 32,22,2,1
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] taps;
      taps = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
      return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
   endfunction

   function automatic logic [31:0] ref_value(input logic [3:0] m, input logic [31:0] r);
      case (m)
         4'd1:    return 32'h7fc00000;
         4'd2:    return 32'h7f800000;
         4'd3:    return 32'hff800000;
         4'd4:    return 32'h7f7fffff;
         4'd5:    return 32'hff7fffff;
         4'd6:    return 32'h00800000;
         4'd7:    return 32'h80800000;
         4'd8:    return 32'h00000001;
         4'd9:    return 32'h80000001;
         4'd10:   return r;
         4'd11:   return 32'h40000000 | ({30'd0, r[1:0]} << 23) | ({29'd0, r[2:0]} << 20);
         4'd12:   return 32'h3f800000;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_pair(input logic [3:0] ma, input logic [3:0] mb, input logic [1:0] opm,
                             input logic [1:0] ord, input int k,
                             output logic [31:0] ea, output logic [31:0] eb, output logic eo);
      logic [31:0] wa, wb, t;
      wa = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      wb = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      ea = ref_value(ma, wa);
      eb = ref_value(mb, wb);
      if ((ord == 2'd1 && ea < eb) || (ord == 2'd2 && ea > eb)) begin
         t = ea; ea = eb; eb = t;
      end
      case (opm)
         2'd0:    eo = 1'b0;
         2'd1:    eo = 1'b1;
         2'd2:    eo = wb[0];
         default: eo = k[0];
      endcase
   endtask

   task automatic load_seed(input logic [31:0] s);
      seed = s;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      m_lfsr = (s == 32'h0) ? 32'h1 : s;
   endtask

   task automatic run_burst(input logic [3:0] ma, input logic [3:0] mb, input logic [1:0] opm,
                            input logic [1:0] ord, input int len, input int stall_pct,
                            input int abort_at, input bit abort_rdy, input bit noisy);
      int          acc, cyc;
      bit          rdy;
      logic [31:0] ea, eb;
      logic        eo;
      mode_a = ma; mode_b = mb; op_mode = opm; order = ord;
      burst_len = 16'(len);
      out_ready = 1'b0;
      start = 1'b1;
      model_pair(ma, mb, opm, ord, 0, ea, eb, eo);
      tick();
      start = 1'b0;
      cyc = 1;
      acc = 0;
      while (cyc < 3000) begin
         check("valid", {31'd0, out_valid}, 32'd1);
         check("busy", {31'd0, busy}, 32'd1);
         check("a", a, ea);
         check("b", b, eb);
         check("op", {31'd0, operation_select}, {31'd0, eo});
         if (abort_at >= 0 && acc == abort_at) begin
            start = 1'b0; seed_load = 1'b0;
            if (!abort_rdy) begin
               out_ready = 1'b0;
               tick();
               check("stall_a", a, ea);
               check("stall_b", b, eb);
            end
            out_ready = abort_rdy;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            out_ready = 1'b0;
            check("abort_valid", {31'd0, out_valid}, 32'd0);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            tick();
            check("abort_done2", {31'd0, done}, 32'd0);
            return;
         end
         rdy = ($urandom_range(0, 99) >= stall_pct);
         out_ready = rdy;
         if (noisy) begin
            start     = 1'($urandom_range(0, 1));
            mode_a    = 4'($urandom_range(0, 15));
            mode_b    = 4'($urandom_range(0, 15));
            op_mode   = 2'($urandom_range(0, 3));
            order     = 2'($urandom_range(0, 3));
            seed_load = 1'($urandom_range(0, 1));
            seed      = $urandom;
         end
         tick();
         cyc++;
         if (rdy) begin
            acc++;
            if (len != 0 && acc == len) begin
               start = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
               check("done", {31'd0, done}, 32'd1);
               check("done_valid", {31'd0, out_valid}, 32'd0);
               if (stall_pct == 0) check("done_cycle", cyc, len + 1);
               tick();
               check("done_clear", {31'd0, done}, 32'd0);
               check("idle_busy", {31'd0, busy}, 32'd0);
               return;
            end
            model_pair(ma, mb, opm, ord, acc, ea, eb, eo);
         end
      end
      n_total++;
      n_fail++;
      $error("FAIL burst_timeout observed=%0d cycles expected=completion", cyc);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
      mode_a = '0; mode_b = '0; op_mode = '0; order = '0; burst_len = '0; seed = '0;
      m_lfsr = 32'h1;
      tick(); tick();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_op", {31'd0, operation_select}, 32'd0);
      check("rst_a", a, 32'd0);
      check("rst_b", b, 32'd0);
      rst_n = 1'b1;
      tick();

      // Fixed specials, subtract, three pairs
      run_burst(4'd2, 4'd1, 2'd1, 2'd0, 3, 0, -1, 1'b0, 1'b0);

      // Random ordered burst, then the same seed again must reproduce it
      load_seed(32'hACE1_2345);
      run_burst(4'd10, 4'd10, 2'd2, 2'd1, 100, 0, -1, 1'b0, 1'b0);
      load_seed(32'hACE1_2345);
      run_burst(4'd10, 4'd10, 2'd2, 2'd1, 100, 20, -1, 1'b0, 1'b0);

      // Backpressure with a<b ordering
      run_burst(4'd10, 4'd11, 2'd0, 2'd2, 4, 50, -1, 1'b0, 1'b0);

      // Alternating operation
      run_burst(4'd12, 4'd4, 2'd3, 2'd0, 5, 0, -1, 1'b0, 1'b0);

      // Unbounded burst aborted while stalled, and abort beating final acceptance
      run_burst(4'd10, 4'd10, 2'd2, 2'd0, 0, 30, 7, 1'b0, 1'b0);
      run_burst(4'd11, 4'd10, 2'd3, 2'd1, 2, 0, 1, 1'b1, 1'b0);

      // Randomised sweep with noisy control inputs mid-burst
      for (int i = 0; i < 10; i++)
         run_burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), $urandom_range(1, 6), 30, -1, 1'b0, 1'b1);

      // Seed value 0 falls back to SEED
      load_seed(32'h0);
      run_burst(4'd10, 4'd10, 2'd2, 2'd0, 2, 0, -1, 1'b0, 1'b0);

      // Reset mid-burst
      load_seed(32'h1234_5678);
      mode_a = 4'd10; mode_b = 4'd10; op_mode = 2'd0; order = 2'd0; burst_len = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_a", a, 32'd0);
      check("rst_mid_b", b, 32'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b0;
      m_lfsr = 32'h1;
      tick();
      check("rst_rel_done", {31'd0, done}, 32'd0);
      check("rst_rel_busy", {31'd0, busy}, 32'd0);
      run_burst(4'd10, 4'd10, 2'd2, 2'd0, 3, 0, -1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
